// File: rtl/p_and_n_pkg.sv
// Default geometry shared by the bitwise AND primitive and its reduction cell.
// Latency: n/a (constants only).
// Backpressure: n/a.
package p_and_n_pkg;

    localparam int DEF_BUS_WIDTH = 4;
    localparam int DEF_NB_INS    = 3;

endpackage : p_and_n_pkg

// File: rtl/p_and_n_and_n.sv
// Scalar NB_INS-input AND reduction; a known 0 on any input dominates.
// Latency: zero (purely combinational).
// Backpressure: none.
module and_n
    import p_and_n_pkg::*;
#(
    parameter int NB_INS = DEF_NB_INS
) (
    output logic              out,
    input  logic [NB_INS-1:0] ins
);

    // Reduction AND over every input bit.
    assign out = &ins;

endmodule : and_n

// File: rtl/p_and_n.sv
// Bitwise AND of NB_INS buses plus a scalar AND reduction, with a registered copy.
// Latency: combinational outputs zero cycles; out_bus_q/out_q/out_valid one cycle.
// Backpressure: none; every cycle with in_valid=1 is captured.
module p_and_n
    import p_and_n_pkg::*;
#(
    parameter int BUS_WIDTH = DEF_BUS_WIDTH,
    parameter int NB_INS    = DEF_NB_INS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NB_INS*BUS_WIDTH-1:0] in_buses,
    input  logic                        in_valid,
    input  logic [NB_INS-1:0]           ins,
    output logic [BUS_WIDTH-1:0]        out_bus,
    output logic                        out,
    output logic [BUS_WIDTH-1:0]        out_bus_q,
    output logic                        out_q,
    output logic                        out_valid
);

    // Scalar reduction path.
    and_n #(.NB_INS(NB_INS)) u_and_ins (
        .out (out),
        .ins (ins)
    );

    // One reduction cell per output bit, fed by that bit column across all buses.
    for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_col
        logic [NB_INS-1:0] col;

        for (genvar k = 0; k < NB_INS; k++) begin : g_tap
            assign col[k] = in_buses[k*BUS_WIDTH + b];
        end

        and_n #(.NB_INS(NB_INS)) u_and_col (
            .out (out_bus[b]),
            .ins (col)
        );
    end

    // Capture stage: valid always follows in_valid, data only loads on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bus_q <= '0;
            out_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bus_q <= out_bus;
                out_q     <= out;
            end
        end
    end

endmodule : p_and_n

// File: tb/tb_p_and_n.sv
module tb_p_and_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Main instance: BUS_WIDTH=4, NB_INS=3
    logic [11:0] in_buses = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  ins = '0;
    logic [3:0]  out_bus, out_bus_q;
    logic        out, out_q, out_valid;

    // NB_INS=4 instance for the reduction ramp
    logic [15:0] in_buses4 = '0;
    logic        in_valid4 = 1'b0;
    logic [3:0]  ins4 = '0;
    logic [3:0]  out_bus4, out_bus_q4;
    logic        out4, out_q4, out_valid4;

    // NB_INS=1, BUS_WIDTH=8 passthrough instance
    logic [7:0]  in_buses1 = '0;
    logic        in_valid1 = 1'b0;
    logic [0:0]  ins1 = '0;
    logic [7:0]  out_bus1, out_bus_q1;
    logic        out1, out_q1, out_valid1;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_bq;
    logic       exp_q;
    logic       exp_v;
    logic [3:0] held_bus;

    p_and_n #(.BUS_WIDTH(4), .NB_INS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_buses(in_buses), .in_valid(in_valid), .ins(ins),
        .out_bus(out_bus), .out(out), .out_bus_q(out_bus_q), .out_q(out_q), .out_valid(out_valid)
    );

    p_and_n #(.BUS_WIDTH(4), .NB_INS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_buses(in_buses4), .in_valid(in_valid4), .ins(ins4),
        .out_bus(out_bus4), .out(out4), .out_bus_q(out_bus_q4), .out_q(out_q4), .out_valid(out_valid4)
    );

    p_and_n #(.BUS_WIDTH(8), .NB_INS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_buses(in_buses1), .in_valid(in_valid1), .ins(ins1),
        .out_bus(out_bus1), .out(out1), .out_bus_q(out_bus_q1), .out_q(out_q1), .out_valid(out_valid1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: an output bit is 1 only if that bit is set in every bus.
    function automatic logic [3:0] ref_bus(input logic [11:0] b);
        logic [3:0] r = 4'hF;
        for (int k = 0; k < 3; k++) r = r & b[k*4 +: 4];
        return r;
    endfunction

    // Reference: the reduction is 1 only when every input is 1.
    function automatic logic ref_red(input logic [2:0] v);
        return (v == 3'b111);
    endfunction

    logic [3:0] ramp [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        // Reset state while rst_n is held low
        #2;
        chk("rst_bus_q", out_bus_q, 0);
        chk("rst_q", out_q, 0);
        chk("rst_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: 1101 & 1011 & 1111 = 1001, single valid pulse
        in_buses = {4'b1111, 4'b1011, 4'b1101};
        ins      = 3'b111;
        in_valid = 1'b1;
        #1;
        chk("dir_bus", out_bus, 4'b1001);
        chk("dir_red", out, 1);
        @(posedge clk); #1;
        chk("dir_bus_q", out_bus_q, 4'b1001);
        chk("dir_q", out_q, 1);
        chk("dir_valid", out_valid, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_buses = 12'h000;
        ins      = 3'b010;
        @(posedge clk); #1;
        chk("dir_valid_drop", out_valid, 0);
        chk("dir_bus_q_held", out_bus_q, 4'b1001);
        chk("dir_q_held", out_q, 1);

        // Hold while in_valid=0 and inputs keep changing
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_buses = 12'(($urandom & 32'hFFF) | 32'hFFF);
            ins      = 3'(i);
            @(posedge clk); #1;
            chk("hold_bus_q", out_bus_q, 4'b1001);
            chk("hold_q", out_q, 1);
            chk("hold_valid", out_valid, 0);
        end

        // Full-ones / any-zero / walking zero in bus 2
        @(negedge clk);
        in_buses = 12'hFFF; #1;
        chk("all_ones", out_bus, 4'hF);
        in_buses = 12'hF0F; #1;
        chk("one_bus_zero", out_bus, 4'h0);
        for (int b = 0; b < 4; b++) begin
            in_buses = 12'hFFF;
            in_buses[8 + b] = 1'b0;
            #1;
            chk("walk0_bus2", out_bus, 4'hF & ~(4'b1 << b));
        end

        // Reduction ramp on the 4-input instance
        for (int i = 0; i < 5; i++) begin
            ins4 = ramp[i];
            #10;
            chk("ramp4", out4, (i == 4) ? 1 : 0);
        end

        // Passthrough instance
        in_buses1 = 8'hA5;
        ins1      = 1'b1;
        #1;
        chk("pass_bus", out_bus1, 8'hA5);
        chk("pass_red", out1, 1);

        // Asynchronous reset mid-stream discards the pending capture
        @(negedge clk);
        in_buses = {4'b1111, 4'b1011, 4'b1101};
        ins      = 3'b111;
        in_valid = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_bus_q", out_bus_q, 0);
        chk("arst_q", out_q, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_comb", out_bus, 4'b1001);
        @(posedge clk); #1;
        chk("arst_hold", out_valid, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_bus_q", out_bus_q, 4'b1001);
        chk("post_rst_valid", out_valid, 1);
        exp_bq = 4'b1001;
        exp_q  = 1'b1;

        // Randomized traffic against the reference
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                in_buses[k*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            ins      = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'($urandom);
            in_valid = ($urandom_range(0, 1) != 0);
            #1;
            chk("rnd_bus", out_bus, ref_bus(in_buses));
            chk("rnd_red", out, ref_red(ins));
            @(posedge clk);
            exp_v = in_valid;
            if (in_valid) begin
                exp_bq = ref_bus(in_buses);
                exp_q  = ref_red(ins);
            end
            #1;
            chk("rnd_valid", out_valid, exp_v);
            chk("rnd_bus_q", out_bus_q, exp_bq);
            chk("rnd_q", out_q, exp_q);
        end

        held_bus = exp_bq;
        @(negedge clk);
        in_valid = 1'b0;
        in_buses = ~in_buses;
        @(posedge clk); #1;
        chk("final_hold", out_bus_q, held_bus);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_p_and_n
